// File: rtl/stop_watch_cu.sv
// -----------------------------------------------------------------------------
// stop_watch_cu -- stopwatch control unit
//
// Purpose:
//   Conditions three raw push-buttons (synchronize, debounce, detect press)
//   and runs the STOP / RUN / CLEAR controller for the stopwatch datapath.
//   It also holds a lap snapshot of the live time and selects between live and
//   frozen time for the display.
//
// Ports:
//   iClk, iRst                 clock (rising edge), asynchronous active-high reset
//   iBtn_Run/Clear/Lap         raw asynchronous push-buttons, active-high
//   imSec/iSec/iMin/iHour      live time from the datapath
//   oRun_Stop                  datapath run enable (state == RUN)
//   oClear                     one-cycle datapath clear strobe (state == CLEAR)
//   odmSec/odSec/odMin/odHour  display time: lap snapshot or live
//   oLap_Hold                  display is showing the frozen lap value
//   oState                     current state code (0 STOP, 1 RUN, 2 CLEAR)
// -----------------------------------------------------------------------------
module stop_watch_cu #(
  parameter int DEBOUNCE_CNT = 100_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iBtn_Run,
  input  logic       iBtn_Clear,
  input  logic       iBtn_Lap,
  input  logic [6:0] imSec,
  input  logic [5:0] iSec,
  input  logic [5:0] iMin,
  input  logic [4:0] iHour,
  output logic       oRun_Stop,
  output logic       oClear,
  output logic [6:0] odmSec,
  output logic [5:0] odSec,
  output logic [5:0] odMin,
  output logic [4:0] odHour,
  output logic       oLap_Hold,
  output logic [1:0] oState
);

  localparam int              CNT_W    = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Button index: 0 = run, 1 = clear, 2 = lap
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {iBtn_Lap, iBtn_Clear, iBtn_Run};

  // ---------------------------------------------------------------------------
  // Per-button conditioning: 2-FF synchronizer, debounce counter, rise detect.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             level_q;
      logic             level_dly_q;
      logic             armed_q;
      logic             pulse_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] idle_q;

      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          sync1_q     <= 1'b0;
          sync2_q     <= 1'b0;
          level_q     <= 1'b0;
          level_dly_q <= 1'b0;
          armed_q     <= 1'b0;
          pulse_q     <= 1'b0;
          cnt_q       <= '0;
          idle_q      <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;

          // Count consecutive cycles the synchronized input disagrees with the
          // accepted level; accept the new level after DEBOUNCE_CNT of them.
          if (sync2_q == level_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end

          // After reset the button must be seen released for a full debounce
          // window before presses count, so a button held through reset
          // never produces a press on release of reset.
          if (!armed_q) begin
            if (sync2_q) begin
              idle_q <= '0;
            end else if (idle_q == CNT_LAST) begin
              idle_q  <= '0;
              armed_q <= 1'b1;
            end else begin
              idle_q <= idle_q + CNT_ONE;
            end
          end

          level_dly_q <= level_q;
          pulse_q     <= armed_q & level_q & ~level_dly_q;
        end
      end

      assign press[gi] = pulse_q;
    end
  endgenerate

  logic run_pulse;
  logic clear_pulse;
  logic lap_pulse;

  assign run_pulse   = press[0];
  assign clear_pulse = press[1];
  assign lap_pulse   = press[2];

  // ---------------------------------------------------------------------------
  // Controller. The state register is a plain 2-bit vector so that the
  // unused code 2'd3 (e.g. after an upset) is representable and recovers.
  // ---------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic       lap_hold_q, lap_hold_d;
  logic [6:0] lap_msec_q, lap_msec_d;
  logic [5:0] lap_sec_q, lap_sec_d;
  logic [5:0] lap_min_q, lap_min_d;
  logic [4:0] lap_hour_q, lap_hour_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= ST_STOP;
      lap_hold_q <= 1'b0;
      lap_msec_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      lap_hour_q <= '0;
    end else begin
      state_q    <= state_d;
      lap_hold_q <= lap_hold_d;
      lap_msec_q <= lap_msec_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      lap_hour_q <= lap_hour_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    lap_msec_d = lap_msec_q;
    lap_sec_d  = lap_sec_q;
    lap_min_d  = lap_min_q;
    lap_hour_d = lap_hour_q;

    case (state_q)
      ST_STOP: begin
        // Priority run > clear > lap; losers in the same cycle are dropped.
        if (run_pulse) begin
          state_d = ST_RUN;
        end else if (clear_pulse) begin
          // Wipe the lap snapshot on entry so CLEAR already shows it cleared.
          state_d    = ST_CLEAR;
          lap_hold_d = 1'b0;
          lap_msec_d = '0;
          lap_sec_d  = '0;
          lap_min_d  = '0;
          lap_hour_d = '0;
        end else if (lap_pulse && lap_hold_q) begin
          lap_hold_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (run_pulse) begin
          state_d = ST_STOP;
        end else if (lap_pulse) begin
          if (lap_hold_q) begin
            lap_hold_d = 1'b0;
          end else begin
            lap_hold_d = 1'b1;
            lap_msec_d = imSec;
            lap_sec_d  = iSec;
            lap_min_d  = iMin;
            lap_hour_d = iHour;
          end
        end
      end

      ST_CLEAR: begin
        state_d    = ST_STOP;
        lap_hold_d = 1'b0;
        lap_msec_d = '0;
        lap_sec_d  = '0;
        lap_min_d  = '0;
        lap_hour_d = '0;
      end

      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

  // Moore outputs decoded from the state register.
  assign oRun_Stop = (state_q == ST_RUN);
  assign oClear    = (state_q == ST_CLEAR);
  assign oState    = state_q;
  assign oLap_Hold = lap_hold_q;

  // Display mux: frozen lap snapshot while holding, live time otherwise.
  assign odmSec = lap_hold_q ? lap_msec_q : imSec;
  assign odSec  = lap_hold_q ? lap_sec_q  : iSec;
  assign odMin  = lap_hold_q ? lap_min_q  : iMin;
  assign odHour = lap_hold_q ? lap_hour_q : iHour;

endmodule

// File: tb/tb_stop_watch_cu.sv
// -----------------------------------------------------------------------------
// tb_stop_watch_cu -- self-checking bench for stop_watch_cu (DEBOUNCE_CNT = 4)
// -----------------------------------------------------------------------------
module tb_stop_watch_cu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_lap = 1'b0;
  logic [6:0] live_ms = 7'd0;
  logic [5:0] live_s  = 6'd0;
  logic [5:0] live_m  = 6'd0;
  logic [4:0] live_h  = 5'd0;

  logic       run_stop, clr_o, lap_hold;
  logic [6:0] d_ms;
  logic [5:0] d_s, d_m;
  logic [4:0] d_h;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Independent activity counters seen from the outputs.
  int   clear_cycles = 0;
  int   run_rises    = 0;
  logic run_prev     = 1'b0;

  stop_watch_cu #(.DEBOUNCE_CNT(4)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iBtn_Run  (btn_run),
    .iBtn_Clear(btn_clr),
    .iBtn_Lap  (btn_lap),
    .imSec     (live_ms),
    .iSec      (live_s),
    .iMin      (live_m),
    .iHour     (live_h),
    .oRun_Stop (run_stop),
    .oClear    (clr_o),
    .odmSec    (d_ms),
    .odSec     (d_s),
    .odMin     (d_m),
    .odHour    (d_h),
    .oLap_Hold (lap_hold),
    .oState    (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_o) clear_cycles++;
    if (run_stop && !run_prev) run_rises++;
    run_prev = run_stop;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_live(input int ms, input int s, input int m, input int h);
    live_ms = 7'(ms);
    live_s  = 6'(s);
    live_m  = 6'(m);
    live_h  = 5'(h);
  endtask

  // Hold the given buttons for 'hold' cycles, release, and let the release
  // debounce fully before returning (returns just after a falling edge).
  task automatic press(input logic r, input logic c, input logic l, input int hold);
    @(negedge clk);
    btn_run = r;
    btn_clr = c;
    btn_lap = l;
    repeat (hold) @(negedge clk);
    btn_run = 1'b0;
    btn_clr = 1'b0;
    btn_lap = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    logic       run;
    logic       clr;
    logic       lap;
    int         hold;
    logic [1:0] exp_state;
    logic       exp_run;
    logic       exp_hold;
  } vec_t;

  vec_t vecs[13];

  int   lap_ms, lap_s, lap_m, lap_h;
  logic prev_hold;
  int   c0, r0, lat;
  logic seen;

  initial begin
    //            run clr lap hold state run hold
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10, 2'd1, 1'b1, 1'b0};  // STOP -> RUN
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 10, 2'd1, 1'b1, 1'b1};  // lap freeze at 00:01:23.45
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 10, 2'd1, 1'b1, 1'b0};  // lap unfreeze
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 10, 2'd0, 1'b0, 1'b0};  // RUN -> STOP
    vecs[4]  = '{1'b1, 1'b0, 1'b0,  3, 2'd0, 1'b0, 1'b0};  // 3-cycle glitch ignored
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 10, 2'd1, 1'b1, 1'b0};  // STOP -> RUN
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 10, 2'd1, 1'b1, 1'b0};  // clear ignored in RUN
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 10, 2'd1, 1'b1, 1'b1};  // lap freeze
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 10, 2'd0, 1'b0, 1'b1};  // stop keeps frozen lap
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 10, 2'd0, 1'b0, 1'b0};  // lap in STOP releases hold
    vecs[10] = '{1'b0, 1'b0, 1'b1, 10, 2'd0, 1'b0, 1'b0};  // lap in STOP w/o hold ignored
    vecs[11] = '{1'b1, 1'b0, 1'b0, 10, 2'd1, 1'b1, 1'b0};  // STOP -> RUN
    vecs[12] = '{1'b1, 1'b0, 1'b0, 10, 2'd0, 1'b0, 1'b0};  // RUN -> STOP

    // ---------------- reset state ----------------
    set_live(11, 22, 33, 4);
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_run", 32'(run_stop), 0);
    chk("rst_clear", 32'(clr_o), 0);
    chk("rst_hold", 32'(lap_hold), 0);
    chk("rst_disp_ms", 32'(d_ms), 11);
    chk("rst_disp_h", 32'(d_h), 4);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    $display("reset: state=%0d run=%0d clear=%0d hold=%0d", state, run_stop, clr_o, lap_hold);

    // ---------------- run press latency ----------------
    r0  = run_rises;
    lat = 0;
    btn_run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (run_stop) begin
        lat = k;
        break;
      end
    end
    repeat (2) @(negedge clk);
    btn_run = 1'b0;
    repeat (12) @(negedge clk);
    $display("latency: run press edge to oRun_Stop = %0d cycles", lat);
    chk("run_latency_7_to_9", 32'((lat >= 7) && (lat <= 9)), 1);
    chk("lat_state", 32'(state), 1);
    chk("lat_single_pulse", 32'(run_rises - r0), 1);
    press(1'b1, 1'b0, 1'b0, 10);
    chk("lat_back_stop", 32'(state), 0);

    // ---------------- table-driven vectors ----------------
    prev_hold = 1'b0;
    lap_ms = 0; lap_s = 0; lap_m = 0; lap_h = 0;
    for (int i = 0; i < 13; i++) begin
      c0 = clear_cycles;
      set_live(42 + 3 * i, 22 + i, 1, 0);
      press(vecs[i].run, vecs[i].clr, vecs[i].lap, vecs[i].hold);
      if (!prev_hold && vecs[i].exp_hold) begin
        lap_ms = 42 + 3 * i;
        lap_s  = 22 + i;
        lap_m  = 1;
        lap_h  = 0;
      end
      prev_hold = vecs[i].exp_hold;
      // Live time moves on; a frozen display must not follow it.
      set_live(62 + 3 * i, 32 + i, 2, 1);
      #1;
      $display("vec %0d: state=%0d run=%0d hold=%0d disp=%0d:%0d:%0d.%0d", i, state, run_stop,
               lap_hold, d_h, d_m, d_s, d_ms);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("v%0d_run", i), 32'(run_stop), 32'(vecs[i].exp_run));
      chk($sformatf("v%0d_hold", i), 32'(lap_hold), 32'(vecs[i].exp_hold));
      chk($sformatf("v%0d_no_clear", i), 32'(clear_cycles - c0), 0);
      chk($sformatf("v%0d_disp_ms", i), 32'(d_ms), vecs[i].exp_hold ? 32'(lap_ms) : 32'(62 + 3 * i));
      chk($sformatf("v%0d_disp_s", i), 32'(d_s), vecs[i].exp_hold ? 32'(lap_s) : 32'(32 + i));
      chk($sformatf("v%0d_disp_m", i), 32'(d_m), vecs[i].exp_hold ? 32'(lap_m) : 32'd2);
      chk($sformatf("v%0d_disp_h", i), 32'(d_h), vecs[i].exp_hold ? 32'(lap_h) : 32'd1);
    end

    // ---------------- clear from STOP with lap held ----------------
    set_live(45, 23, 1, 0);
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    press(1'b1, 1'b0, 1'b0, 10);
    chk("clr_pre_hold", 32'(lap_hold), 1);
    chk("clr_pre_state", 32'(state), 0);
    c0 = clear_cycles;
    seen = 1'b0;
    btn_clr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state == 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("clr_state_seen", 32'(seen), 1);
    chk("clr_strobe", 32'(clr_o), 1);
    chk("clr_hold_zero", 32'(lap_hold), 0);
    chk("clr_lap_regs_zero", 32'({dut.lap_msec_q, dut.lap_sec_q, dut.lap_min_q, dut.lap_hour_q}), 0);
    chk("clr_disp_live", 32'(d_ms), 45);
    @(negedge clk);
    chk("clr_next_state", 32'(state), 0);
    chk("clr_next_strobe", 32'(clr_o), 0);
    btn_clr = 1'b0;
    repeat (12) @(negedge clk);
    $display("clear: strobe cycles=%0d state=%0d hold=%0d", clear_cycles - c0, state, lap_hold);
    chk("clr_one_cycle", 32'(clear_cycles - c0), 1);

    // ---------------- run and clear together ----------------
    c0 = clear_cycles;
    press(1'b1, 1'b1, 1'b0, 10);
    $display("run+clear: state=%0d strobes=%0d", state, clear_cycles - c0);
    chk("both_state_run", 32'(state), 1);
    chk("both_no_clear", 32'(clear_cycles - c0), 0);

    // ---------------- illegal state recovery ----------------
    @(negedge clk);
    force dut.state_q = 2'd3;
    #1;
    chk("ill_state_3", 32'(state), 3);
    chk("ill_run_low", 32'(run_stop), 0);
    @(posedge clk);
    #1;
    release dut.state_q;
    @(negedge clk);
    @(negedge clk);
    $display("illegal: state after recovery=%0d", state);
    chk("ill_recover_stop", 32'(state), 0);

    // ---------------- reset while a button is held in RUN ----------------
    press(1'b1, 1'b0, 1'b0, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    chk("hrst_pre_run", 32'(run_stop), 1);
    chk("hrst_pre_hold", 32'(lap_hold), 1);
    @(negedge clk);
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("hrst_state", 32'(state), 0);
    chk("hrst_run", 32'(run_stop), 0);
    chk("hrst_clear", 32'(clr_o), 0);
    chk("hrst_hold", 32'(lap_hold), 0);
    @(negedge clk);
    rst = 1'b0;
    r0 = run_rises;
    repeat (20) @(negedge clk);
    chk("hrst_no_pulse_held", 32'(run_rises - r0), 0);
    btn_run = 1'b0;
    repeat (12) @(negedge clk);
    chk("hrst_no_pulse_release", 32'(state), 0);
    press(1'b1, 1'b0, 1'b0, 10);
    $display("reset-held: state after re-press=%0d rises=%0d", state, run_rises - r0);
    chk("hrst_repress_run", 32'(state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
